// File: rtl/au_cmp_serial_pkg.sv
// Shared types and sizing helpers for the serial digit comparator.
package au_cmp_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Counter wide enough to hold 1..n.
  function automatic int steps_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Index wide enough to hold 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/au_cmp_chunk.sv
// Combinational single-digit compare; sgn treats the digit as two's complement.
module au_cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             sgn,
  output logic             digit_eq,
  output logic             digit_gt
);

  logic signed [CHUNK:0] xs;
  logic signed [CHUNK:0] ys;

  // Extending by the sign bit (or zero) lets one signed compare serve both modes.
  always_comb begin
    xs       = signed'({sgn & x[CHUNK-1], x});
    ys       = signed'({sgn & y[CHUNK-1], y});
    digit_eq = (x == y);
    digit_gt = (xs > ys);
  end

endmodule

// File: rtl/au_cmp_serial.sv
// Iterative MSB-first magnitude/equality comparator with early exit on the first unequal digit.
module au_cmp_serial
  import au_cmp_serial_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CHUNK  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [WIDTH-1:0]                     a,
  input  logic [WIDTH-1:0]                     b,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 eq,
  output logic                                 lt,
  output logic                                 gt,
  output logic [$clog2(WIDTH/CHUNK+1)-1:0]     steps
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int SW     = steps_w(NCHUNK);
  localparam int IW     = idx_w(NCHUNK);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("au_cmp_serial: WIDTH must be a positive multiple of CHUNK");
  end

  state_t            state, state_nx;
  logic [WIDTH-1:0]  a_r, a_nx, b_r, b_nx;
  logic [IW-1:0]     idx, idx_nx;
  logic [SW-1:0]     cnt, cnt_nx, steps_nx;
  logic              eq_nx, lt_nx, gt_nx;
  logic              sgn, digit_eq, digit_gt;

  // Only the most significant digit carries the sign.
  assign sgn = SIGNED && (idx == IW'(NCHUNK - 1));

  au_cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x        (a_r[idx*CHUNK +: CHUNK]),
    .y        (b_r[idx*CHUNK +: CHUNK]),
    .sgn      (sgn),
    .digit_eq (digit_eq),
    .digit_gt (digit_gt)
  );

  always_comb begin
    state_nx = state;
    a_nx     = a_r;
    b_nx     = b_r;
    idx_nx   = idx;
    cnt_nx   = cnt;
    eq_nx    = eq;
    lt_nx    = lt;
    gt_nx    = gt;
    steps_nx = steps;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_nx     = a;
          b_nx     = b;
          idx_nx   = IW'(NCHUNK - 1);
          cnt_nx   = SW'(1);
          state_nx = RUN;
        end
      end
      RUN: begin
        if (!digit_eq) begin
          eq_nx    = 1'b0;
          gt_nx    = digit_gt;
          lt_nx    = !digit_gt;
          steps_nx = cnt;
          state_nx = DONE;
        end else if (idx == '0) begin
          eq_nx    = 1'b1;
          gt_nx    = 1'b0;
          lt_nx    = 1'b0;
          steps_nx = cnt;
          state_nx = DONE;
        end else begin
          idx_nx = idx - IW'(1);
          cnt_nx = cnt + SW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      idx       <= '0;
      cnt       <= '0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      gt        <= 1'b0;
      steps     <= '0;
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == DONE);
      a_r       <= a_nx;
      b_r       <= b_nx;
      idx       <= idx_nx;
      cnt       <= cnt_nx;
      eq        <= eq_nx;
      lt        <= lt_nx;
      gt        <= gt_nx;
      steps     <= steps_nx;
    end
  end

endmodule

// File: tb/tb_au_cmp_serial.sv
// Directed-table and model-based bench for au_cmp_serial across several parameter sets.
module tb_au_cmp_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  localparam logic [2:0] R_EQ = 3'b100;
  localparam logic [2:0] R_LT = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;

  // 32-bit, 8-bit digits: unsigned (u0) and signed (u1) in lockstep
  logic        iv_a, or_a;
  logic [31:0] a32, b32;
  logic        ir0, ov0, eq0, lt0, gt0;
  logic [2:0]  st0;
  logic        ir1, ov1, eq1, lt1, gt1;
  logic [2:0]  st1;
  // 8-bit, 2-bit digits: unsigned (u2) and signed (u3)
  logic        iv_b, or_b;
  logic [7:0]  a8, b8;
  logic        ir2, ov2, eq2, lt2, gt2;
  logic [2:0]  st2;
  logic        ir3, ov3, eq3, lt3, gt3;
  logic [2:0]  st3;
  // single digit, signed (u4)
  logic        iv_c, or_c;
  logic        ir4, ov4, eq4, lt4, gt4;
  logic [0:0]  st4;

  au_cmp_serial #(.WIDTH(32), .CHUNK(8), .SIGNED(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir0), .a(a32), .b(b32),
    .out_valid(ov0), .out_ready(or_a), .eq(eq0), .lt(lt0), .gt(gt0), .steps(st0));
  au_cmp_serial #(.WIDTH(32), .CHUNK(8), .SIGNED(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir1), .a(a32), .b(b32),
    .out_valid(ov1), .out_ready(or_a), .eq(eq1), .lt(lt1), .gt(gt1), .steps(st1));
  au_cmp_serial #(.WIDTH(8), .CHUNK(2), .SIGNED(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir2), .a(a8), .b(b8),
    .out_valid(ov2), .out_ready(or_b), .eq(eq2), .lt(lt2), .gt(gt2), .steps(st2));
  au_cmp_serial #(.WIDTH(8), .CHUNK(2), .SIGNED(1'b1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir3), .a(a8), .b(b8),
    .out_valid(ov3), .out_ready(or_b), .eq(eq3), .lt(lt3), .gt(gt3), .steps(st3));
  au_cmp_serial #(.WIDTH(32), .CHUNK(32), .SIGNED(1'b1)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .in_ready(ir4), .a(a32), .b(b32),
    .out_valid(ov4), .out_ready(or_c), .eq(eq4), .lt(lt4), .gt(gt4), .steps(st4));

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input int w, input bit sgn,
                                         input logic [31:0] x, input logic [31:0] y);
    longint xv, yv;
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    xv = longint'(x & mask);
    yv = longint'(y & mask);
    if (sgn && x[w-1]) xv = xv - (longint'(1) << w);
    if (sgn && y[w-1]) yv = yv - (longint'(1) << w);
    if (xv == yv) return R_EQ;
    return (xv < yv) ? R_LT : R_GT;
  endfunction

  function automatic int ref_steps(input int w, input int ch,
                                   input logic [31:0] x, input logic [31:0] y);
    logic [31:0] diff;
    diff = x ^ y;
    for (int i = w - 1; i >= 0; i--)
      if (diff[i]) return w / ch - i / ch;
    return w / ch;
  endfunction

  task automatic run_a(input logic [31:0] x, input logic [31:0] y, input int stall,
                       input bit poke, output logic [2:0] r0, output logic [2:0] r1,
                       output int s0, output int s1, output int lat);
    @(negedge clk);
    check("a_in_ready_idle", ir0, 1);
    a32 = x; b32 = y; iv_a = 1'b1;
    @(posedge clk); #1;
    iv_a = 1'b0;
    lat = 0;
    while (!ov0 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("a_out_valid_seen", ov0, 1);
    check("a_lockstep_valid", ov1, 1);
    r0 = {eq0, lt0, gt0}; s0 = int'(st0);
    r1 = {eq1, lt1, gt1}; s1 = int'(st1);
    for (int k = 0; k < stall; k++) begin
      if (poke && k == 0) begin
        a32 = ~x; b32 = x; iv_a = 1'b1;
      end
      @(posedge clk); #1;
      check("a_stall_hold", {ov0, ir0, eq0, lt0, gt0, st0}, {1'b1, 1'b0, r0, 3'(s0)});
    end
    iv_a = 1'b0;
    or_a = 1'b1;
    @(posedge clk); #1;
    or_a = 1'b0;
    check("a_release_idle", {ov0, ir0}, 2'b01);
    if (poke) begin
      @(posedge clk); #1;
      check("a_poke_not_taken", {ov0, ir0}, 2'b01);
    end
  endtask

  task automatic run_b(input logic [7:0] x, input logic [7:0] y, input int stall,
                       output logic [2:0] r2, output logic [2:0] r3,
                       output int s2, output int s3);
    int lat;
    @(negedge clk);
    a8 = x; b8 = y; iv_b = 1'b1;
    @(posedge clk); #1;
    iv_b = 1'b0;
    lat = 0;
    while (!ov2 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b_out_valid_seen", {ov2, ov3}, 2'b11);
    r2 = {eq2, lt2, gt2}; s2 = int'(st2);
    r3 = {eq3, lt3, gt3}; s3 = int'(st3);
    repeat (stall) @(posedge clk);
    #1 or_b = 1'b1;
    @(posedge clk); #1;
    or_b = 1'b0;
  endtask

  task automatic run_c(input logic [31:0] x, input logic [31:0] y,
                       output logic [2:0] r, output int s, output int lat);
    @(negedge clk);
    a32 = x; b32 = y; iv_c = 1'b1;
    @(posedge clk); #1;
    iv_c = 1'b0;
    lat = 0;
    while (!ov4 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("c_out_valid_seen", ov4, 1);
    r = {eq4, lt4, gt4}; s = int'(st4);
    or_c = 1'b1;
    @(posedge clk); #1;
    or_c = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  res_u;
    logic [2:0]  res_s;
    int          steps;
  } vec_t;

  initial begin
    vec_t        tbl[9];
    logic [2:0]  r0, r1, r2, r3;
    int          s0, s1, s2, s3, lat;
    logic [7:0]  bl[16];
    logic [31:0] x, y, mask;
    int          k;
    bit          seen;

    tbl[0] = '{32'h1234_5678, 32'h1234_5678, R_EQ, R_EQ, 4};
    tbl[1] = '{32'h8000_0000, 32'h7FFF_FFFF, R_GT, R_LT, 1};
    tbl[2] = '{32'h1234_56FF, 32'h1234_5600, R_GT, R_GT, 4};
    tbl[3] = '{32'h1200_5678, 32'h12FF_5678, R_LT, R_LT, 2};
    tbl[4] = '{32'hFFFF_FFFF, 32'h0000_0000, R_GT, R_LT, 1};
    tbl[5] = '{32'h0000_0000, 32'h0000_0001, R_LT, R_LT, 4};
    tbl[6] = '{32'hFF00_0000, 32'hFE00_0000, R_GT, R_GT, 1};
    tbl[7] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, R_LT, R_GT, 1};
    tbl[8] = '{32'h1234_8000, 32'h1234_7FFF, R_GT, R_GT, 3};

    rst_n = 1'b0;
    iv_a = 1'b0; or_a = 1'b0; iv_b = 1'b0; or_b = 1'b0; iv_c = 1'b0; or_c = 1'b0;
    a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {ir0, ov0, eq0, lt0, gt0, st0}, {1'b1, 1'b0, 3'b000, 3'd0});
    check("reset_state_b", {ir2, ov2, ir4, ov4}, 4'b1010);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_a(tbl[i].a, tbl[i].b, 0, 1'b0, r0, r1, s0, s1, lat);
      check($sformatf("tbl%0d_unsigned", i), r0, tbl[i].res_u);
      check($sformatf("tbl%0d_signed", i), r1, tbl[i].res_s);
      check($sformatf("tbl%0d_steps", i), s0, tbl[i].steps);
      check($sformatf("tbl%0d_steps_s", i), s1, tbl[i].steps);
      check($sformatf("tbl%0d_latency", i), lat, tbl[i].steps);
    end

    // Backpressure with a competing request during DONE
    run_a(32'h1234_56FF, 32'h1234_5600, 5, 1'b1, r0, r1, s0, s1, lat);
    check("bp_result", r0, R_GT);
    check("bp_steps", s0, 4);

    // Single-digit configuration
    run_c(32'h8000_0000, 32'h7FFF_FFFF, r0, s0, lat);
    check("c_sign_result", r0, R_LT);
    check("c_sign_steps", s0, 1);
    check("c_latency", lat, 1);
    run_c(32'hDEAD_BEEF, 32'hDEAD_BEEF, r0, s0, lat);
    check("c_eq_result", r0, R_EQ);
    check("c_eq_steps", s0, 1);
    run_c(32'h0000_0005, 32'h0000_0003, r0, s0, lat);
    check("c_gt_result", r0, R_GT);

    // Reset in the middle of RUN, leaving nonzero results from the last op
    run_a(32'h1234_56FF, 32'h1234_5600, 0, 1'b0, r0, r1, s0, s1, lat);
    @(negedge clk);
    a32 = 32'h1234_5678; b32 = 32'h1234_5678; iv_a = 1'b1;
    @(posedge clk); #1;
    iv_a = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrun_reset_state", {ir0, ov0, eq0, lt0, gt0, st0}, {1'b1, 1'b0, 3'b000, 3'd0});
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ov0 || ov1) seen = 1'b1;
    end
    check("midrun_no_valid", seen, 0);
    run_a(32'h1200_5678, 32'h12FF_5678, 0, 1'b0, r0, r1, s0, s1, lat);
    check("post_reset_result", r0, R_LT);
    check("post_reset_steps", s0, 2);

    // 8-bit, 2-bit digits: every a against boundary and near-a values of b
    for (int ai = 0; ai < 256; ai++) begin
      bl = '{8'h00, 8'h01, 8'h3F, 8'h40, 8'h7F, 8'h80, 8'h81, 8'hBF, 8'hC0, 8'hFE, 8'hFF,
             8'(ai), 8'(ai ^ 1), 8'(ai ^ 4), 8'(ai ^ 16), 8'(ai ^ 64)};
      for (int j = 0; j < 16; j++) begin
        run_b(8'(ai), bl[j], (ai + j) % 2, r2, r3, s2, s3);
        check("x8_unsigned", r2, ref_cmp(8, 1'b0, 32'(ai), 32'(bl[j])));
        check("x8_signed", r3, ref_cmp(8, 1'b1, 32'(ai), 32'(bl[j])));
        check("x8_steps", {s2, s3}, {ref_steps(8, 2, 32'(ai), 32'(bl[j])),
                                     ref_steps(8, 2, 32'(ai), 32'(bl[j]))});
      end
    end

    // Random 32-bit pairs sharing a random-length prefix, with random stalls
    for (int i = 0; i < 2000; i++) begin
      x = $urandom;
      k = $urandom_range(0, 4);
      mask = (k == 4) ? 32'h0 : (32'hFFFF_FFFF >> (8 * k));
      y = x ^ ($urandom & mask);
      if (k == 0) y = $urandom;
      run_a(x, y, $urandom_range(0, 3), 1'b0, r0, r1, s0, s1, lat);
      check("rnd_unsigned", r0, ref_cmp(32, 1'b0, x, y));
      check("rnd_signed", r1, ref_cmp(32, 1'b1, x, y));
      check("rnd_steps", s0, ref_steps(32, 8, x, y));
      check("rnd_steps_s", s1, ref_steps(32, 8, x, y));
      check("rnd_latency", lat, ref_steps(32, 8, x, y));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
